// File: rtl/aes_inv_cntx.sv
// aes_inv_cntx: AES inverse-cipher round sequencer. It runs the shared forward
//   key schedule for NR steps and captures each round key. It then replays the
//   keys from NR down to 0 while driving the inverse-round enables.
// Latency: 1 accept step + NR key-expansion steps + NR+1 decrypt steps, counted
//   in start-high cycles. done rises on the edge that ends the last decrypt step.
// Backpressure: the sequencer advances only in cycles with start=1. With start=0
//   all state and the key store hold, and the outputs hold their values.
// Ports:
//   clk, rstn         clock; synchronous active-low reset
//   start             step enable
//   rk_in             round key from key expansion (cipher key in the accept cycle)
//   accept            idle, ready for a new key/ciphertext
//   rndNo             current round-key index
//   enbKS             key-expansion step enable
//   enbISR/ISB/AR/IMC inverse-round stage enables for the decrypt datapath
//   rk_out            round key for the current decrypt step (0 outside DEC)
//   done              operation complete; held until the next accept
//   completed_round   one-hot decrypt progress (bit0 at rndNo=NR-1)
module aes_inv_cntx #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [KW-1:0] rk_in,
  output logic          accept,
  output logic [3:0]    rndNo,
  output logic          enbKS,
  output logic          enbISR,
  output logic          enbISB,
  output logic          enbAR,
  output logic          enbIMC,
  output logic [KW-1:0] rk_out,
  output logic          done,
  output logic [NR-1:0] completed_round
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2
  } phase_t;

  localparam logic [3:0] NR_C = 4'(NR);

  phase_t        phase_q, phase_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [KW-1:0] store_q [0:NR];

  logic          wr_en;
  logic [3:0]    wr_idx;
  logic          in_dec;

  // Next-state logic. Nothing moves unless start is high. A count outside
  // 0..NR or an unused phase encoding falls back to IDLE.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    wr_en   = 1'b0;
    // IDLE always captures into slot 0, whatever the counter holds.
    wr_idx  = (phase_q == IDLE) ? 4'd0 : cnt_q;
    if (start) begin
      case (phase_q)
        IDLE: begin
          wr_en   = 1'b1;
          phase_d = KEYEXP;
          cnt_d   = 4'd1;
          done_d  = 1'b0;
        end
        KEYEXP: begin
          if (cnt_q > NR_C) begin
            phase_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            wr_en = 1'b1;
            if (cnt_q == NR_C) begin
              // Last key captured. Decrypt starts at the same index.
              phase_d = DEC;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        DEC: begin
          if (cnt_q > NR_C) begin
            phase_d = IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == 4'd0) begin
            phase_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          phase_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (wr_en) begin
        for (int i = 0; i <= NR; i++) begin
          if (wr_idx == 4'(i)) begin
            store_q[i] <= rk_in;
          end
        end
      end
    end
  end

  // Output decode. Every output depends only on registered state.
  assign in_dec = (phase_q == DEC);
  assign accept = (phase_q == IDLE);
  assign rndNo  = (phase_q == KEYEXP || phase_q == DEC) ? cnt_q : 4'd0;
  assign enbKS  = (phase_q == KEYEXP);
  assign enbAR  = in_dec;
  // At the first decrypt step (rndNo=NR) only AddRoundKey runs. At the last
  // step (rndNo=0) InvMixColumns is skipped, mirroring the encrypt order.
  assign enbISR = in_dec && (rndNo < NR_C);
  assign enbISB = in_dec && (rndNo < NR_C);
  assign enbIMC = in_dec && (rndNo != 4'd0) && (rndNo < NR_C);
  assign done   = done_q;

  always_comb begin
    rk_out = '0;
    if (in_dec) begin
      for (int i = 0; i <= NR; i++) begin
        if (rndNo == 4'(i)) begin
          rk_out = store_q[i];
        end
      end
    end
  end

  always_comb begin
    completed_round = '0;
    for (int i = 0; i < NR; i++) begin
      completed_round[i] = in_dec && (rndNo == 4'(NR - 1 - i));
    end
  end

endmodule

// File: tb/tb_aes_inv_cntx.sv
// tb_aes_inv_cntx: scoreboard bench for the AES inverse round sequencer.
// Latency: expected steps are queued when a run starts and popped per start-high step.
// Backpressure: start is dropped mid-run to check that the sequencer freezes.
`timescale 1ns/1ps
module tb_aes_inv_cntx;
  localparam int NR = 10;
  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] rk_in = '0;
  logic          accept, enbKS, enbISR, enbISB, enbAR, enbIMC, done;
  logic [3:0]    rndNo;
  logic [KW-1:0] rk_out;
  logic [NR-1:0] completed_round;

  aes_inv_cntx #(.NR(NR), .KW(KW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .rk_in(rk_in),
    .accept(accept), .rndNo(rndNo), .enbKS(enbKS), .enbISR(enbISR),
    .enbISB(enbISB), .enbAR(enbAR), .enbIMC(enbIMC), .rk_out(rk_out),
    .done(done), .completed_round(completed_round)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [18:0]   ctl;
    logic [KW-1:0] rk;
  } exp_t;

  exp_t          q[$];
  logic [KW-1:0] keys [0:NR];
  logic [KW-1:0] dp_state = '0;
  logic [7:0]    sbox  [0:255];
  logic [7:0]    isbox [0:255];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ctl_now();
    return {enbKS, enbAR, enbISR, enbISB, enbIMC, rndNo, completed_round};
  endfunction

  function automatic exp_t mk_ks(input logic [3:0] r);
    exp_t e;
    e.ctl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, r, 10'b0};
    e.rk  = '0;
    return e;
  endfunction

  function automatic exp_t mk_dec(input logic [3:0] r, input logic [KW-1:0] k);
    exp_t       e;
    logic       isr, imc;
    logic [9:0] cr;
    isr = (r <= 4'd9);
    imc = (r >= 4'd1) && (r <= 4'd9);
    cr  = (r <= 4'd9) ? (10'b1 << (9 - r)) : 10'b0;
    e.ctl = {1'b0, 1'b1, isr, isr, imc, r, cr};
    e.rk  = k;
    return e;
  endfunction

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, aa = a, bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b, x, s;
    for (int a = 0; a < 256; a++) begin
      x = 8'(a);
      b = 8'h01;
      if (a == 0) b = 8'h00;
      else repeat (254) b = gmul(b, x);
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = x;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] inv_step(input logic [127:0] s, input logic isr,
                                            input logic isb, input logic imc,
                                            input logic [127:0] k);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    if (isr) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r+4*c] = b[r + 4*((c - r + 4) % 4)];
      b = t;
    end
    if (isb) for (int i = 0; i < 16; i++) b[i] = isbox[b[i]];
    for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
    if (imc) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
        b[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
        b[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
        b[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rstn && start && (enbKS || enbAR)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got step rndNo=%0d expected no step", rndNo);
      end else begin
        e = q.pop_front();
        chk("sb_ctl", 128'(ctl_now()), 128'(e.ctl));
        chk("sb_rk", rk_out, e.rk);
      end
      if (enbAR) dp_state = inv_step(dp_state, enbISR, enbISB, enbIMC, rk_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pause3(input logic [3:0] r, input bit dec);
    exp_t e;
    e = dec ? mk_dec(r, keys[r]) : mk_ks(r);
    start = 1'b0;
    rk_in = 128'hdeadbeef_cafef00d_0badc0de_feedface;
    repeat (3) begin
      cycle();
      chk("pause_ctl", 128'(ctl_now()), 128'(e.ctl));
      chk("pause_rk", rk_out, e.rk);
      chk("pause_done", 128'(done), 128'd0);
    end
    start = 1'b1;
  endtask

  task automatic run_op(input bit fips, input int pause_ks, input int pause_dec, input int abort_at);
    for (int r = 1; r <= NR; r++) q.push_back(mk_ks(4'(r)));
    for (int r = NR; r >= 0; r--) q.push_back(mk_dec(4'(r), keys[r]));
    chk("accept_before", 128'(accept), 128'd1);
    start = 1'b1;
    rk_in = keys[0];
    cycle();
    chk("done_acc_after_accept", 128'({done, accept}), 128'd0);
    for (int r = 1; r <= NR; r++) begin
      if (r == pause_ks) pause3(4'(r), 1'b0);
      rk_in = keys[r];
      cycle();
    end
    for (int r = NR; r >= 0; r--) begin
      rk_in = ~keys[r];
      if (fips && r == NR) chk("fips_rk10", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      if (r == abort_at) begin
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        start = 1'b0;
        q.delete();
        chk("abort_done_acc", 128'({done, accept}), 128'b01);
        chk("abort_ctl", 128'(ctl_now()), 128'd0);
        chk("abort_rk", rk_out, 128'd0);
        return;
      end
      if (r == pause_dec) pause3(4'(r), 1'b1);
      if (r == 0) chk("done_before_last", 128'({done, accept}), 128'd0);
      cycle();
    end
    chk("done_at_end", 128'({done, accept}), 128'b11);
    chk("scoreboard_drained", 128'(q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();

    // Reset with start high: reset must win.
    rstn = 1'b0;
    start = 1'b1;
    rk_in = 128'h0123456789abcdef0123456789abcdef;
    repeat (3) cycle();
    rstn = 1'b1;
    start = 1'b0;
    cycle();
    chk("reset_done_acc", 128'({done, accept}), 128'b01);
    chk("reset_ctl", 128'(ctl_now()), 128'd0);
    chk("reset_rk", rk_out, 128'd0);
    repeat (2) cycle();
    chk("idle_hold", 128'({done, accept, ctl_now()}), 128'(21'b01 << 19));

    // FIPS-197 C.1 decrypt through the bench datapath.
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    dp_state = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    run_op(1'b1, -1, -1, -1);
    chk("fips_plain", dp_state, 128'h00112233445566778899aabbccddeeff);
    start = 1'b0;

    // Freeze at KEYEXP cnt=5 and at DEC rndNo=4.
    for (int i = 0; i <= NR; i++) keys[i] = {4{32'h9e3779b9 * 32'(i + 1)}} ^ {120'h0, 8'(i)};
    run_op(1'b0, 5, 4, -1);
    start = 1'b0;
    repeat (2) cycle();
    chk("done_held", 128'({done, accept}), 128'b11);
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    chk("reset_clears_done", 128'({done, accept}), 128'b01);

    // Reset in the middle of decrypt.
    run_op(1'b0, -1, -1, 6);

    // Two back-to-back operations, start held high throughout.
    for (int i = 0; i <= NR; i++) keys[i] = {16{8'(8'h11 * i + 8'h03)}};
    run_op(1'b0, -1, -1, -1);
    for (int i = 0; i <= NR; i++) keys[i] = {8{16'(16'hbeef - 16'(i) * 16'h0101)}};
    run_op(1'b0, -1, -1, -1);
    start = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
